// File: rtl/osd_regaccess_initiator_if.sv
// Local request/response and DII flit ports of the register-access initiator.
// The master modport is the initiator itself; slave is the surrounding logic.
interface osd_regaccess_initiator_if #(
    parameter int MAX_REG_SIZE = 64
);
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

    logic                    req_valid;
    logic                    req_ready;
    logic [15:0]             req_dest;
    logic                    req_write;
    logic [15:0]             req_addr;
    logic [1:0]              req_size;
    logic [MAX_REG_SIZE-1:0] req_wdata;
    logic                    resp_valid;
    logic                    resp_err;
    logic [MAX_REG_SIZE-1:0] resp_rdata;
    dii_flit                 debug_out;
    logic                    debug_out_ready;
    dii_flit                 debug_in;
    logic                    debug_in_ready;

    modport master (
        input  req_valid, req_dest, req_write, req_addr, req_size, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output debug_out,
        input  debug_out_ready,
        input  debug_in,
        output debug_in_ready
    );

    modport slave (
        output req_valid, req_dest, req_write, req_addr, req_size, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  debug_out,
        output debug_out_ready,
        output debug_in,
        input  debug_in_ready
    );
endinterface

// File: rtl/osd_regaccess_initiator.sv
// OSD REG access initiator: one local request -> request packet, then decode of the reply.
// Define OSD_REGACCESS_INITIATOR_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES with an error.
//
// state | meaning
// IDLE  | ready for a request; oversize requests fail here without a packet
// SEND  | transmitting dest, src, header, addr and write data words
// WAIT  | parsing response flits, draining foreign/non-matching packets
// DONE  | one-cycle completion pulse
module osd_regaccess_initiator #(
    parameter int MAX_REG_SIZE   = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               id,
    osd_regaccess_initiator_if.master bus
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
    localparam logic [31:0] MAX_BITS = 32'(MAX_REG_SIZE);

    state_t                  st, st_nx;
    logic [15:0]             dest_q, addr_q;
    logic                    wr_q;
    logic [1:0]              size_q;
    logic [MAX_REG_SIZE-1:0] wdata_q, rsh, rsh_nx, rdata_q;
    logic [3:0]              flit_cnt, nwords, nflits, widx;
    logic [4:0]              pos;
    logic                    drop, ovf, err_q;
    logic                    oversize, flit_last;
    logic [15:0]             flit_data;
    logic                    in_v, in_l;
    logic [15:0]             in_d;
    logic [3:0]              sub;
    logic                    type_ok, rd_ok, rd_err, wr_ok, wr_err, hdr_match;
    logic                    fin, fin_err, tmo_hit;

    assign in_v = bus.debug_in.valid;
    assign in_l = bus.debug_in.last;
    assign in_d = bus.debug_in.data;

    assign oversize  = (32'd16 << bus.req_size) > MAX_BITS;
    assign nwords    = 4'd1 << size_q;
    assign nflits    = wr_q ? 4'd4 + nwords : 4'd4;
    assign flit_last = (flit_cnt == nflits - 4'd1);
    // data flit k carries word N-1-(k-4), so the most significant word goes first
    assign widx      = nwords - flit_cnt + 4'd3;

    always_comb begin
        flit_data = 16'h0000;
        case (flit_cnt)
            4'd0:    flit_data = dest_q;
            4'd1:    flit_data = id;
            4'd2:    flit_data = {2'b00, 1'b0, wr_q, size_q, 10'd0};
            4'd3:    flit_data = addr_q;
            default: flit_data = 16'(wdata_q >> {widx, 4'b0000});
        endcase
    end

    assign bus.req_ready      = (st == IDLE);
    assign bus.resp_valid     = (st == DONE) | ovf;
    assign bus.resp_err       = err_q;
    assign bus.resp_rdata     = rdata_q;
    assign bus.debug_in_ready = 1'b1;
    assign bus.debug_out      = {st == SEND, flit_last, flit_data};

    assign sub       = in_d[13:10];
    assign type_ok   = (in_d[15:14] == 2'b00);
    assign rd_ok     = type_ok && !wr_q && (sub == {2'b10, size_q});
    assign rd_err    = type_ok && !wr_q && (sub == 4'b1100);
    assign wr_ok     = type_ok &&  wr_q && (sub == 4'b1110);
    assign wr_err    = type_ok &&  wr_q && (sub == 4'b1111);
    assign hdr_match = rd_ok | rd_err | wr_ok | wr_err;
    assign rsh_nx    = (rsh << 16) | MAX_REG_SIZE'(in_d);

`ifdef OSD_REGACCESS_INITIATOR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo;

    assign tmo_hit = (tmo == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || st != WAIT) tmo <= '0;
        else                   tmo <= tmo + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        st_nx   = st;
        fin     = 1'b0;
        fin_err = 1'b0;
        case (st)
            IDLE: if (bus.req_valid && !oversize) st_nx = SEND;
            SEND: if (bus.debug_out_ready && flit_last) st_nx = WAIT;
            WAIT: begin
                if (in_v && !drop) begin
                    if (pos == 5'd2 && (rd_err || wr_ok || wr_err)) begin
                        fin     = 1'b1;
                        fin_err = !wr_ok || !in_l;
                    end else if (pos == 5'd2 && rd_ok && in_l) begin
                        fin     = 1'b1;
                        fin_err = 1'b1;
                    end else if (pos >= 5'd3 && in_l) begin
                        fin     = 1'b1;
                        fin_err = (pos - 5'd2) != {1'b0, nwords};
                    end
                end
                if (!fin && tmo_hit) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
                if (fin) st_nx = DONE;
            end
            DONE:    st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDLE;
            dest_q   <= '0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            size_q   <= '0;
            wdata_q  <= '0;
            flit_cnt <= '0;
            pos      <= '0;
            drop     <= 1'b0;
            rsh      <= '0;
            ovf      <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            st  <= st_nx;
            ovf <= 1'b0;
            case (st)
                IDLE: if (bus.req_valid) begin
                    if (oversize) begin
                        ovf     <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        dest_q   <= bus.req_dest;
                        addr_q   <= bus.req_addr;
                        wr_q     <= bus.req_write;
                        size_q   <= bus.req_size;
                        wdata_q  <= bus.req_wdata;
                        flit_cnt <= '0;
                    end
                end
                SEND: if (bus.debug_out_ready) begin
                    flit_cnt <= flit_cnt + 4'd1;
                    if (flit_last) begin
                        pos  <= '0;
                        drop <= 1'b0;
                        rsh  <= '0;
                    end
                end
                WAIT: begin
                    if (in_v) begin
                        if (in_l)              pos <= '0;
                        else if (pos != 5'h1f) pos <= pos + 5'd1;
                        // a foreign source or unexpected header drains to the end of its packet
                        if (in_l)
                            drop <= 1'b0;
                        else if (!drop && ((pos == 5'd1 && in_d != dest_q) ||
                                           (pos == 5'd2 && !hdr_match)))
                            drop <= 1'b1;
                        if (!drop && pos >= 5'd3 && (pos - 5'd3) < {1'b0, nwords})
                            rsh <= rsh_nx;
                    end
                    if (fin) begin
                        err_q   <= fin_err;
                        rdata_q <= (fin_err || wr_q) ? '0 : rsh_nx;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_osd_regaccess_initiator.sv
// Scoreboard bench for osd_regaccess_initiator: directed requests, hand-written
// expected flits/responses queued by the stimulus and checked by a monitor.
module tb_osd_regaccess_initiator;
    localparam int MRS = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] id  = 16'h0001;

    osd_regaccess_initiator_if #(.MAX_REG_SIZE(MRS)) bus();

    osd_regaccess_initiator #(.MAX_REG_SIZE(MRS), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk),
        .rst(rst),
        .id(id),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vecs   = 0;
    int miscmp = 0;

    typedef struct {
        logic [15:0] d;
        logic        l;
    } flit_t;

    typedef struct {
        logic        err;
        logic [63:0] rd;
        logic        chk_rd;
        logic        rdy;
        int          cyc;
    } rsp_t;

    flit_t exp_f[$];
    rsp_t  exp_r[$];
    logic  bp_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic ef(input logic [15:0] d, input logic l);
        flit_t f;
        f.d = d;
        f.l = l;
        exp_f.push_back(f);
    endtask

    task automatic er(input logic e, input logic [63:0] rd, input logic c, input logic rdy, input int cy);
        rsp_t r;
        r.err = e; r.rd = rd; r.chk_rd = c; r.rdy = rdy; r.cyc = cy;
        exp_r.push_back(r);
    endtask

    task automatic req(input logic wr, input logic [15:0] dest, input logic [15:0] addr,
                       input logic [1:0] sz, input logic [63:0] wd);
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_write = wr;
        bus.req_dest  = dest;
        bus.req_addr  = addr;
        bus.req_size  = sz;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic put(input logic [15:0] d, input logic l);
        bus.debug_in = {1'b1, l, d};
        @(posedge clk);
        #1;
        bus.debug_in = '0;
    endtask

    task automatic wait_sent();
        int t = 0;
        while (exp_f.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (exp_f.size() != 0) begin
            vecs++;
            miscmp++;
            $display("FAIL send_timeout: %0d flits pending, expected 0", exp_f.size());
            exp_f.delete();
        end
    endtask

    task automatic wait_resp();
        int t = 0;
        while (exp_r.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (exp_r.size() != 0) begin
            vecs++;
            miscmp++;
            $display("FAIL resp_timeout: %0d responses pending, expected 0", exp_r.size());
            exp_r.delete();
        end
    endtask

    // downstream ready: steady 1, or the pattern 1,0,0 repeating when bp_en
    initial begin
        int ph = 0;
        bus.debug_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                ph = (ph == 2) ? 0 : ph + 1;
                bus.debug_out_ready = (ph == 0);
            end else begin
                bus.debug_out_ready = 1'b1;
            end
        end
    end

    // monitor: checks every accepted flit, stall stability and every completion
    initial begin
        flit_t       f;
        rsp_t        r;
        logic        stall_pend = 1'b0;
        logic [15:0] stall_d = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.debug_out.valid) begin
                    if (stall_pend) chk("stall_stable", 64'(bus.debug_out.data), 64'(stall_d));
                    if (bus.debug_out_ready) begin
                        stall_pend = 1'b0;
                        if (exp_f.size() == 0) begin
                            vecs++;
                            miscmp++;
                            $display("FAIL unexpected_flit: got %h expected none", bus.debug_out.data);
                        end else begin
                            f = exp_f.pop_front();
                            chk("flit_data", 64'(bus.debug_out.data), 64'(f.d));
                            chk("flit_last", 64'(bus.debug_out.last), 64'(f.l));
                        end
                    end else begin
                        stall_pend = 1'b1;
                        stall_d    = bus.debug_out.data;
                    end
                end else begin
                    stall_pend = 1'b0;
                end
                if (bus.resp_valid) begin
                    if (exp_r.size() == 0) begin
                        vecs++;
                        miscmp++;
                        $display("FAIL unexpected_resp: got err=%0b expected no response", bus.resp_err);
                    end else begin
                        r = exp_r.pop_front();
                        chk("resp_err", 64'(bus.resp_err), 64'(r.err));
                        if (r.chk_rd) chk("resp_rdata", bus.resp_rdata, r.rd);
                        chk("resp_req_ready", 64'(bus.req_ready), 64'(r.rdy));
                        chk("resp_cycle", 64'(cyc), 64'(r.cyc));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_dest  = '0;
        bus.req_addr  = '0;
        bus.req_size  = '0;
        bus.req_wdata = '0;
        bus.debug_in  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready",  64'(bus.req_ready), 64'd1);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_err",   64'(bus.resp_err), 64'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
        chk("rst_out_valid",  64'(bus.debug_out.valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 16-bit read
        ef(16'h0005, 0); ef(16'h0001, 0); ef(16'h0000, 0); ef(16'h0200, 1);
        req(0, 16'h0005, 16'h0200, 2'd0, 64'd0);
        wait_sent();
        put(16'h0001, 0); put(16'h0005, 0); put(16'h2000, 0); put(16'hBEEF, 1);
        er(0, 64'h0000_0000_0000_BEEF, 1, 0, cyc);
        wait_resp();

        // 32-bit write
        ef(16'h0005, 0); ef(16'h0001, 0); ef(16'h1400, 0); ef(16'h0010, 0);
        ef(16'h1234, 0); ef(16'h5678, 1);
        req(1, 16'h0005, 16'h0010, 2'd1, 64'h1234_5678);
        wait_sent();
        put(16'h0001, 0); put(16'h0005, 0); put(16'h3800, 1);
        er(0, 64'd0, 0, 0, cyc);
        wait_resp();

        // 32-bit read
        ef(16'h0005, 0); ef(16'h0001, 0); ef(16'h0400, 0); ef(16'h0044, 1);
        req(0, 16'h0005, 16'h0044, 2'd1, 64'd0);
        wait_sent();
        put(16'h0001, 0); put(16'h0005, 0); put(16'h2400, 0); put(16'hCAFE, 0); put(16'h0123, 1);
        er(0, 64'h0000_0000_CAFE_0123, 1, 0, cyc);
        wait_resp();

        // read error response clears rdata
        ef(16'h0005, 0); ef(16'h0001, 0); ef(16'h0400, 0); ef(16'h0046, 1);
        req(0, 16'h0005, 16'h0046, 2'd1, 64'd0);
        wait_sent();
        put(16'h0001, 0); put(16'h0005, 0); put(16'h3000, 1);
        er(1, 64'd0, 1, 0, cyc);
        wait_resp();

        // 64-bit read
        ef(16'h0005, 0); ef(16'h0001, 0); ef(16'h0800, 0); ef(16'h0100, 1);
        req(0, 16'h0005, 16'h0100, 2'd2, 64'd0);
        wait_sent();
        put(16'h0001, 0); put(16'h0005, 0); put(16'h2800, 0);
        put(16'h0123, 0); put(16'h4567, 0); put(16'h89AB, 0); put(16'hCDEF, 1);
        er(0, 64'h0123_4567_89AB_CDEF, 1, 0, cyc);
        wait_resp();

        // oversize 128-bit request: no packet, error pulse next cycle, still ready
        er(1, 64'd0, 1, 1, cyc + 1);
        req(0, 16'h0005, 16'h0020, 2'd3, 64'd0);
        wait_resp();

        // 64-bit write under backpressure
        ef(16'h0007, 0); ef(16'h0001, 0); ef(16'h1800, 0); ef(16'h0033, 0);
        ef(16'h1111, 0); ef(16'h2222, 0); ef(16'h3333, 0); ef(16'h4444, 1);
        bp_en = 1'b1;
        req(1, 16'h0007, 16'h0033, 2'd2, 64'h1111_2222_3333_4444);
        wait_sent();
        bp_en = 1'b0;
        put(16'h0001, 0); put(16'h0007, 0); put(16'h3800, 1);
        er(0, 64'd0, 0, 0, cyc);
        wait_resp();

        // foreign packet drained before the matching reply
        ef(16'h0005, 0); ef(16'h0001, 0); ef(16'h0000, 0); ef(16'h0300, 1);
        req(0, 16'h0005, 16'h0300, 2'd0, 64'd0);
        wait_sent();
        put(16'h0001, 0); put(16'h0009, 0); put(16'h2000, 0); put(16'hDEAD, 1);
        put(16'h0001, 0); put(16'h0005, 0); put(16'h2000, 0); put(16'h0042, 1);
        er(0, 64'h42, 1, 0, cyc);
        wait_resp();

        // read-ok reply that ends one word short
        ef(16'h0005, 0); ef(16'h0001, 0); ef(16'h0400, 0); ef(16'h0048, 1);
        req(0, 16'h0005, 16'h0048, 2'd1, 64'd0);
        wait_sent();
        put(16'h0001, 0); put(16'h0005, 0); put(16'h2400, 0); put(16'hAAAA, 1);
        er(1, 64'd0, 1, 0, cyc);
        wait_resp();

`ifdef OSD_REGACCESS_INITIATOR_TIMEOUT_EN
        // no reply: error exactly 16 cycles after entering WAIT; late reply ignored
        ef(16'h0005, 0); ef(16'h0001, 0); ef(16'h0000, 0); ef(16'h0010, 1);
        req(0, 16'h0005, 16'h0010, 2'd0, 64'd0);
        wait_sent();
        er(1, 64'd0, 1, 0, cyc + 16);
        wait_resp();
        put(16'h0001, 0); put(16'h0005, 0); put(16'h2000, 0); put(16'h1234, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("late_resp_rdata", bus.resp_rdata, 64'd0);
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("flits_left", 64'(exp_f.size()), 64'd0);
        chk("resps_left", 64'(exp_r.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end
endmodule

// File: doc/osd_regaccess_initiator.md
Name: osd_regaccess_initiator

Overview:
- Master side of the debug register access protocol: turns one local register request into an OSD REG request packet on a DII link, then waits for and decodes the matching response.
- Used by debug modules that must read or write registers of other debug modules (e.g. host-interface/control modules).
- Sits between module-local control logic and a debug ring port; one transaction outstanding at a time.

Parameters:
- MAX_REG_SIZE, 64: widest supported register in bits; one of 16/32/64/128.
- TIMEOUT_CYCLES, 1024: response timeout in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id  in  16  own DI address, used as the request source
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_dest  in  16  target module address
- req_write  in  1  1=write, 0=read
- req_addr  in  16  register address
- req_size  in  2  0=16, 1=32, 2=64, 3=128 bits
- req_wdata  in  MAX_REG_SIZE  write data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  error flag, valid with resp_valid
- resp_rdata  out  MAX_REG_SIZE  read data, right-aligned, zero-extended
- debug_out  out  dii_flit  request flits: valid, last, data[15:0]
- debug_out_ready  in  1  downstream ready
- debug_in  in  dii_flit  response flits
- debug_in_ready  out  1  always 1 (never backpressures)

Behaviour:
- Reset: state IDLE; req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, debug_out.valid=0. Reset mid-packet abandons the packet; the next request starts at flit 0.
- Word count N = 1<<req_size (1, 2, 4, 8 sixteen-bit words).
- Header encoding: type [15:14]=2'b00 (REG); subtype [13:10]:
  - requests: read 4'b00SS, write 4'b01SS (SS=req_size)
  - responses: read ok 4'b10SS, read err 4'b1100, write ok 4'b1110, write err 4'b1111
  - bits [9:0]=0.
- Request packet, transmitted in order: dest, src=id, header, addr, then for writes N data words MSB-word first. last is set on the final flit (addr flit for reads).
- States:
  - IDLE: req_ready=1.
    - If req_valid and 16<<req_size > MAX_REG_SIZE: no packet; resp_valid=1, resp_err=1 in the next cycle; stay IDLE.
    - Otherwise latch all req_* fields and go to SEND.
  - SEND: req_ready=0; debug_out.valid=1. The flit counter advances only on valid&debug_out_ready; data and last are held stable while stalled. The last flit accepted moves to WAIT.
  - WAIT: consume debug_in flits every cycle.
    - Flit 0 (dest) is ignored.
    - If flit 1 (src) != latched dest, or the header type/subtype does not match the outstanding request, drain that packet up to last and remain in WAIT.
    - Matching read-ok: shift N data words in MSB first, then go to DONE.
    - Matching error or write-ok headers: go to DONE on that flit, which must carry last.
    - A matching read-ok packet with last before N words, or with extra words: resp_err=1.
  - DONE: one cycle; resp_valid=1; return to IDLE. req_ready is 0 during DONE and 1 again in IDLE the cycle after.
- resp_rdata holds its value until the next completion. On errors resp_rdata=0.
- Latency, read 16-bit with debug_out_ready=1: 4 flit cycles to send; resp_valid 1 cycle after the response's last flit is accepted.

Optional Feature:
- Macro: OSD_REGACCESS_INITIATOR_TIMEOUT_EN.
- Defined: a counter is cleared on entering WAIT and incremented each WAIT cycle.
  - Reaching TIMEOUT_CYCLES goes to DONE with resp_err=1.
  - A response arriving afterwards is drained as non-matching.
- Undefined: no counter; WAIT persists until a matching response arrives.

Test Plan:
- Read: id=0x0001, dest=0x0005, addr=0x0200, size=0, debug_out_ready=1 -> flits 0x0005, 0x0001, 0x0000, 0x0200(last). Response 0x0001, 0x0005, 0x2000, 0xBEEF(last) -> resp_valid=1, resp_err=0, resp_rdata=0xBEEF.
- Write 32-bit: addr=0x0010, wdata=0x12345678 -> flits dest, src, 0x1400, 0x0010, 0x1234, 0x5678(last). Response header 0x3800 -> resp_err=0.
- Backpressure: debug_out_ready toggles 1,0,0,1,... during SEND -> flit sequence identical, no duplicated or skipped flit, data stable while stalled.
- Error and oversize:
  - Read-error response (header 0x3000) -> resp_err=1, rdata=0.
  - Request size=3 with MAX_REG_SIZE=64 -> no debug_out.valid, error pulse next cycle.
- Foreign packet: in WAIT, a packet from src 0x0009 arrives before the matching one -> it is drained, no resp_valid; the subsequent matching response completes normally.
- Timeout (macro defined, TIMEOUT_CYCLES=16): no response -> resp_valid=1, resp_err=1 exactly 16 cycles after entering WAIT; a late response is dropped.
